// File: rtl/sr_latch_driver.sv
// rtl/sr_latch_driver.sv - timed set/clear pulse driver with read-back check for an active-low NAND SR latch
// Optional feedback synchronizer: define SR_LATCH_DRIVER_FB_SYNC_EN.
module sr_latch_driver #(
   parameter int PULSE_W = 2,
   parameter int GAP_W   = 1,
   parameter int CNT_W   = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req_valid,
   input  logic       req_set,
   output logic       req_ready,
   output logic [1:0] sr,
   input  logic       q_fb,
   output logic       done,
   output logic       err,
   output logic       busy
);

   localparam logic [1:0] SR_SET   = 2'b01;
   localparam logic [1:0] SR_CLEAR = 2'b10;
   localparam logic [1:0] SR_HOLD  = 2'b11;

   localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_W - 1);
`ifdef SR_LATCH_DRIVER_FB_SYNC_EN
   // Two extra settle cycles cover the synchronizer depth.
   localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(GAP_W + 1);
`else
   localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(GAP_W - 1);
`endif

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      PULSE  = 2'd1,
      SETTLE = 2'd2,
      CHECK  = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             exp_q, exp_d;
   logic [1:0]       sr_q, sr_d;
   logic             done_q, done_d;
   logic             err_q, err_d;
   logic             busy_q, busy_d;
   logic             fb_s;

`ifdef SR_LATCH_DRIVER_FB_SYNC_EN
   logic [1:0] sync_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_q <= 2'b00;
      end else begin
         sync_q <= {sync_q[0], q_fb};
      end
   end

   assign fb_s = sync_q[1];
`else
   assign fb_s = q_fb;
`endif

   assign req_ready = (state_q == IDLE) && rst_n;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         exp_q   <= 1'b0;
         sr_q    <= SR_HOLD;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         exp_q   <= exp_d;
         sr_q    <= sr_d;
         done_q  <= done_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      exp_d   = exp_q;
      case (state_q)
         IDLE: begin
            if (req_valid && req_ready) begin
               state_d = PULSE;
               cnt_d   = PULSE_LOAD;
               exp_d   = req_set;
            end
         end
         PULSE: begin
            if (cnt_q == '0) begin
               state_d = SETTLE;
               cnt_d   = SETTLE_LOAD;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         SETTLE: begin
            if (cnt_q == '0) begin
               state_d = CHECK;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs are computed from the next state so sr only ever moves between hold and one code.
   always_comb begin
      sr_d   = SR_HOLD;
      done_d = 1'b0;
      err_d  = 1'b0;
      busy_d = (state_d != IDLE);
      if (state_d == PULSE) begin
         sr_d = exp_d ? SR_SET : SR_CLEAR;
      end
      if (state_d == CHECK) begin
         done_d = 1'b1;
         err_d  = (fb_s != exp_q);
      end
   end

   assign sr   = sr_q;
   assign done = done_q;
   assign err  = err_q;
   assign busy = busy_q;

endmodule

// File: tb/tb_sr_latch_driver.sv
// tb/tb_sr_latch_driver.sv - scoreboard bench for sr_latch_driver with a behavioural NAND latch model
module tb_sr_latch_driver;

   localparam int PW = 2;
   localparam int GW = 1;
`ifdef SR_LATCH_DRIVER_FB_SYNC_EN
   localparam int LAT = PW + GW + 2;
`else
   localparam int LAT = PW + GW;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic       req_valid;
   logic       req_set;
   logic       req_ready;
   logic [1:0] sr;
   logic       q_fb;
   logic       done;
   logic       err;
   logic       busy;

   logic q_lat = 1'b0;
   logic stuck = 1'b0;

   typedef struct {
      logic err;
      int   acc;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;
   int   n_done  = 0;
   int   run     = 0;
   logic skip_run = 1'b0;
   logic started  = 1'b0;
   logic [1:0] prev_sr = 2'b11;

   sr_latch_driver #(.PULSE_W(PW), .GAP_W(GW), .CNT_W(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_set   (req_set),
      .req_ready (req_ready),
      .sr        (sr),
      .q_fb      (q_fb),
      .done      (done),
      .err       (err),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   assign q_fb = stuck ? 1'b1 : q_lat;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Latch model and scoreboard push on the accepting edge.
   always @(posedge clk) begin
      exp_t e;
      cyc++;
      if (sr == 2'b01) q_lat <= 1'b1;
      else if (sr == 2'b10) q_lat <= 1'b0;
      if (rst_n && req_valid && req_ready) begin
         e.err = stuck ? !req_set : 1'b0;
         e.acc = cyc;
         sb.push_back(e);
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (started) begin
         chk("sr_not_00", (sr == 2'b00), 0);
         chk("sr_no_direct", (prev_sr != 2'b11 && sr != 2'b11 && sr != prev_sr), 0);
         if (sr != 2'b11) begin
            run++;
         end else begin
            if (run != 0 && !skip_run) chk("pulse_len", run, PW);
            if (run != 0) skip_run = 1'b0;
            run = 0;
         end
         if (err && !done) chk("err_without_done", err, 0);
         if (done) begin
            n_done++;
            if (sb.size() == 0) begin
               chk("spurious_done", done, 0);
            end else begin
               e = sb.pop_front();
               chk("err", err, e.err);
               chk("latency", cyc - e.acc, LAT);
            end
         end
         prev_sr = sr;
      end
   end

   task automatic wait_done(input int target);
      for (int i = 0; i < 60 && n_done < target; i++) begin
         @(negedge clk);
         #1;
      end
      if (n_done < target) chk("timeout", n_done, target);
   endtask

   task automatic do_req(input logic set, input logic stk);
      int t;
      t = n_done + 1;
      @(negedge clk);
      stuck     = stk;
      req_set   = set;
      req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      wait_done(t);
      @(negedge clk);
      chk("ready_after", req_ready, 1);
      chk("busy_after", busy, 0);
   endtask

   initial begin
      int t;
      rst_n     = 1'b0;
      req_valid = 1'b1;
      req_set   = 1'b1;
      @(posedge clk);
      started = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_sr", sr, 2'b11);
         chk("rst_ready", req_ready, 0);
         chk("rst_done", done, 0);
         chk("rst_err", err, 0);
         chk("rst_busy", busy, 0);
      end
      req_valid = 1'b0;
      rst_n     = 1'b1;
      @(negedge clk);
      chk("ready_post_rst", req_ready, 1);
      chk("sr_post_rst", sr, 2'b11);

      do_req(1'b1, 1'b0);
      chk("q_after_set", q_lat, 1);
      do_req(1'b0, 1'b1);
      do_req(1'b1, 1'b1);
      stuck = 1'b0;
      do_req(1'b1, 1'b0);
      do_req(1'b0, 1'b0);
      chk("q_after_clear", q_lat, 0);

      // Back-to-back with req_valid held high; switch to clear while done is up.
      t = n_done;
      @(negedge clk);
      req_set   = 1'b1;
      req_valid = 1'b1;
      wait_done(t + 1);
      req_set = 1'b0;
      wait_done(t + 2);
      req_valid = 1'b0;
      @(negedge clk);
      chk("b2b_q", q_lat, 0);

      // Reset during the second pulse cycle drops the request.
      t = n_done;
      @(negedge clk);
      req_set   = 1'b1;
      req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      chk("mid_sr_code", sr, 2'b01);
      rst_n    = 1'b0;
      skip_run = 1'b1;
      sb.delete();
      @(negedge clk);
      chk("mid_rst_sr", sr, 2'b11);
      chk("mid_rst_busy", busy, 0);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      chk("mid_no_done", n_done, t);
      do_req(1'b0, 1'b0);
      chk("q_after_mid", q_lat, 0);

      for (int i = 0; i < 6; i++) begin
         do_req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      stuck = 1'b0;
      repeat (3) @(negedge clk);
      chk("sb_empty", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
